bcd_counter_display: RTL and testbench

//  Multi-digit decimal up/down counter advanced by the slow divided clock from the divide-by-10 stage.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_counter_display.sv | 81 ++++++++
 tb/tb_bcd_counter_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Seven-segment codes (active-low, {g,f,e,d,c,b,a}) and the BCD-to-segment decoder
// shared by the counter digits and the display register.
package bcd_pkg;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit: clear > load > step. carry_out is combinational so the
// carry/borrow ripples through all digits within the same step cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst,
  input  logic       step_in,
  input  logic       up,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = step_in & (up ? (digit == DIGIT_MAX) : (digit == 4'd0));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      // Non-decimal load nibbles are forced to 0 so the digit never leaves 0..9
      digit <= (load_val > DIGIT_MAX) ? 4'd0 : load_val;
    end else if (step_in) begin
      if (up) digit <= (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0) ? DIGIT_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter stepped by rising edges of the asynchronous iTick,
// with wrap pulse and a registered seven-segment display one cycle behind the count.
module bcd_counter_display
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iTick,
  input  logic                iEn,
  input  logic                iUp,
  input  logic                iClear,
  input  logic                iLoad,
  input  logic [4*DIGITS-1:0] iLoadVal,
  output logic [4*DIGITS-1:0] oBcd,
  output logic [7*DIGITS-1:0] oSeg,
  output logic                oWrap
);

  logic s1, s2, s3;
  logic step;
  logic [DIGITS:0] chain;
  logic [7*DIGITS-1:0] seg_nxt;
  logic lead;

  // Flops reset high so a tick already high at reset release is not seen as an edge
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= iTick;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step     = s2 & ~s3;
  assign chain[0] = step & iEn & ~iClear & ~iLoad;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .iClk      (iClk),
      .iRst      (iRst),
      .step_in   (chain[g]),
      .up        (iUp),
      .clear     (iClear),
      .load      (iLoad),
      .load_val  (iLoadVal[4*g +: 4]),
      .digit     (oBcd[4*g +: 4]),
      .carry_out (chain[g+1])
    );
  end

  // Carry out of the top digit means every digit rolled over
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) oWrap <= 1'b0;
    else       oWrap <= chain[DIGITS];
  end

  always_comb begin
    seg_nxt = '0;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (BLANK_LZ && lead && (i != 0) && (oBcd[4*i +: 4] == 4'd0))
        seg_nxt[7*i +: 7] = SEG_BLANK;
      else
        seg_nxt[7*i +: 7] = bcd_to_seg(oBcd[4*i +: 4]);
      if (oBcd[4*i +: 4] != 4'd0) lead = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) oSeg <= {DIGITS{SEG_0}};
    else       oSeg <= seg_nxt;
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench: two counters (leading-zero blanking off/on) driven identically and compared each
// cycle against a decimal-integer reference model.
module tb_bcd_counter_display;

  localparam int M = 10000;

  logic        clk;
  logic        rst_n;
  logic        tick_i, en_i, up_i, clear_i, load_i;
  logic [15:0] load_val_i;
  logic [15:0] bcd, bcd_lz;
  logic [27:0] seg, seg_lz;
  logic        wrap, wrap_lz;

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_seen = 0;

  int          cnt;
  logic        m_wrap;
  logic [27:0] m_seg, m_seg_lz;
  logic        t1, t2, t3;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_counter_display #(.DIGITS(4), .BLANK_LZ(1'b0)) dut (
    .iClk(clk), .iRst(rst_n), .iTick(tick_i), .iEn(en_i), .iUp(up_i),
    .iClear(clear_i), .iLoad(load_i), .iLoadVal(load_val_i),
    .oBcd(bcd), .oSeg(seg), .oWrap(wrap)
  );

  bcd_counter_display #(.DIGITS(4), .BLANK_LZ(1'b1)) dut_lz (
    .iClk(clk), .iRst(rst_n), .iTick(tick_i), .iEn(en_i), .iUp(up_i),
    .iClear(clear_i), .iLoad(load_i), .iLoadVal(load_val_i),
    .oBcd(bcd_lz), .oSeg(seg_lz), .oWrap(wrap_lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [27:0] to_seg(input int v, input bit lz);
    logic [27:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (lz && i > 0 && v < pow10(i)) r[7*i +: 7] = 7'h7f;
      else r[7*i +: 7] = seg_tab[(v / pow10(i)) % 10];
    end
    return r;
  endfunction

  function automatic int coerce(input logic [15:0] lv);
    int v = 0;
    for (int i = 0; i < 4; i++)
      if (lv[4*i +: 4] <= 4'd9) v = v + int'(lv[4*i +: 4]) * pow10(i);
    return v;
  endfunction

  task automatic model_reset();
    cnt      = 0;
    m_wrap   = 1'b0;
    m_seg    = {4{7'h40}};
    m_seg_lz = {4{7'h40}};
    t1 = 1'b1; t2 = 1'b1; t3 = 1'b1;
  endtask

  // A tick first sampled high at edge k counts at edge k+2; the display shows the
  // count that was present before each edge.
  task automatic model_edge();
    logic stepv;
    m_seg    = to_seg(cnt, 1'b0);
    m_seg_lz = to_seg(cnt, 1'b1);
    stepv    = t2 & ~t3;
    m_wrap   = 1'b0;
    if (clear_i) cnt = 0;
    else if (load_i) cnt = coerce(load_val_i);
    else if (stepv && en_i) begin
      if (up_i) begin
        m_wrap = (cnt == M - 1);
        cnt = (cnt + 1) % M;
      end else begin
        m_wrap = (cnt == 0);
        cnt = (cnt + M - 1) % M;
      end
    end
    t3 = t2; t2 = t1; t1 = tick_i;
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
    check("bcd", 32'(bcd), 32'(to_bcd(cnt)));
    check("bcd_lz", 32'(bcd_lz), 32'(to_bcd(cnt)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("wrap_lz", 32'(wrap_lz), 32'(m_wrap));
    check("seg", 32'(seg), 32'(m_seg));
    check("seg_lz", 32'(seg_lz), 32'(m_seg_lz));
    if (wrap) wrap_seen++;
    @(negedge clk);
  endtask

  task automatic tick(input int hi, input int lo);
    tick_i = 1'b1;
    repeat (hi) step_clk();
    tick_i = 1'b0;
    repeat (lo) step_clk();
  endtask

  task automatic load_value(input logic [15:0] v);
    load_i = 1'b1;
    load_val_i = v;
    step_clk();
    load_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_i = 1'b1; en_i = 1'b0; up_i = 1'b1;
    clear_i = 1'b0; load_i = 1'b0; load_val_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Tick held high through reset release gives no step
    en_i = 1'b1;
    repeat (20) step_clk();
    check("t1_bcd", 32'(bcd), 32'h0);
    check("t1_wraps", wrap_seen, 0);

    tick_i = 1'b0;
    repeat (5) step_clk();
    for (int n = 0; n < 12; n++) tick(5, 5);
    check("t2_bcd", 32'(bcd), 32'h0012);
    check("t2_seg0", 32'(seg[6:0]), 32'h24);

    // Full wrap up, then down
    load_value(16'h9998);
    wrap_seen = 0;
    tick(5, 5);
    check("t3_9999", 32'(bcd), 32'h9999);
    tick(5, 5);
    check("t3_0000", 32'(bcd), 32'h0);
    check("t3_wraps1", wrap_seen, 1);
    up_i = 1'b0;
    tick(5, 5);
    check("t3_down", 32'(bcd), 32'h9999);
    check("t3_wraps2", wrap_seen, 2);

    // Load coinciding with a step: step dropped, bad nibbles coerced
    up_i = 1'b1;
    tick_i = 1'b1;
    step_clk();
    step_clk();
    load_value(16'h1A3F);
    check("t4_load", 32'(bcd), 32'h1030);
    repeat (3) step_clk();
    tick_i = 1'b0;
    repeat (5) step_clk();
    check("t4_hold", 32'(bcd), 32'h1030);
    clear_i = 1'b1;
    load_value(16'h5555);
    clear_i = 1'b0;
    check("t4_clear", 32'(bcd), 32'h0);

    // Disabled ticks are discarded
    load_value(16'h0005);
    en_i = 1'b0;
    repeat (3) tick(4, 4);
    en_i = 1'b1;
    tick(4, 4);
    check("t5_en", 32'(bcd), 32'h0006);
    tick(4, 4);
    tick_i = 1'b1;
    step_clk();
    step_clk();
    step_clk();
    tick_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_bcd", 32'(bcd), 32'h0);
    check("t5_rst_seg", 32'(seg), 32'(28'h8102040));
    check("t5_rst_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step_clk();

    // Leading-zero blanking
    load_value(16'h0040);
    step_clk();
    check("t6_0040", 32'(seg_lz), 32'({7'h7f, 7'h7f, 7'h19, 7'h40}));
    load_value(16'h0000);
    step_clk();
    check("t6_0000", 32'(seg_lz), 32'({7'h7f, 7'h7f, 7'h7f, 7'h40}));

    // Random ticks with random control and occasional load/clear
    for (int n = 0; n < 250; n++) begin
      int hi, lo;
      hi = $urandom_range(3, 7);
      lo = $urandom_range(3, 7);
      for (int c = 0; c < hi + lo; c++) begin
        tick_i  = (c < hi);
        en_i    = ($urandom_range(0, 3) != 0);
        up_i    = ($urandom_range(0, 2) != 0);
        clear_i = ($urandom_range(0, 59) == 0);
        load_i  = ($urandom_range(0, 29) == 0);
        case ($urandom_range(0, 3))
          0:       load_val_i = 16'h9998;
          1:       load_val_i = 16'h0001;
          default: load_val_i = 16'($urandom);
        endcase
        step_clk();
      end
    end
    clear_i = 1'b0;
    load_i  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
